// File: rtl/mont_arbiter_pkg.sv
// Shared definitions for the two-requester Montgomery multiplier arbiter.
// Holds the default datapath width, requester count and controller state encoding.
package mont_arbiter_pkg;

  localparam int W_DEF = 381;
  localparam int NREQ  = 2;

  // Requester 0 must win the first tie, so the pointer starts at requester 1.
  localparam logic LAST_RESET = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone requester wins outright; on a tie the requester not served last wins.
module rr_pick2
  import mont_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/mont_arbiter.sv
// Arbitrates two requesters onto one external Montgomery multiplier.
// Operands are captured at grant and held steady until the multiplier reports completion.
module mont_arbiter
  import mont_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  input  logic [W-1:0]    m,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic            mm_start,
  output logic [W-1:0]    mm_a,
  output logic [W-1:0]    mm_b,
  output logic [W-1:0]    mm_m,
  input  logic [W-1:0]    mm_result,
  input  logic            mm_done
);

  state_t          state;
  logic            owner;
  logic            last;
  logic [NREQ-1:0] win;

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .win  (win)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= LAST_RESET;
      gnt      <= '0;
      done     <= '0;
      mm_start <= 1'b0;
      result   <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      gnt      <= '0;
      done     <= '0;
      mm_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= win[1];
            mm_a     <= win[1] ? a1 : a0;
            mm_b     <= win[1] ? b1 : b0;
            mm_m     <= m;
            gnt      <= win;
            mm_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // Only here is mm_done meaningful; elsewhere it is ignored.
          if (mm_done) begin
            result <= mm_result;
            done   <= {owner, ~owner};
            state  <= RESP;
          end
        end
        RESP: begin
          last  <= owner;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mont_arbiter.md
MONT_ARBITER -- requirements
Module: mont_arbiter

Interface
REQ-001 Parameter W, default 381, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  2  SHALL carry one level request bit per requester (bit 0 = requester 0).
REQ-005 a0, b0  input  W  SHALL be requester 0's operands, valid while req[0]=1.
REQ-006 a1, b1  input  W  SHALL be requester 1's operands, valid while req[1]=1.
REQ-007 m  input  W  SHALL be the shared modulus, sampled at grant.
REQ-008 gnt  output  2  SHALL be a one-hot, one-cycle pulse marking operand capture for the winner.
REQ-009 done  output  2  SHALL be a one-hot, one-cycle pulse to the owner when result is valid.
REQ-010 result  output  W  SHALL hold the last completed product until the next completion.
REQ-011 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-012 mm_start  output  1  SHALL be the start pulse to the shared Montgomery multiplier.
REQ-013 mm_a, mm_b, mm_m  output  W  SHALL be registered operands driven to the multiplier.
REQ-014 mm_result  input  W  SHALL be the multiplier result.
REQ-015 mm_done  input  1  SHALL be the multiplier's one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding 2 bits.
REQ-017 IDLE: when req != 0, the controller SHALL pick a winner, register its a/b and m into mm_a/mm_b/mm_m, record owner, and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins outright; with both requesting, the one not served last wins.
REQ-019 ISSUE: gnt[owner]=1 and mm_start=1 for exactly this cycle; next state WAIT.
REQ-020 WAIT: mm_a/mm_b/mm_m SHALL stay stable; on mm_done=1 the controller SHALL capture mm_result into result and go to RESP.
REQ-021 RESP: done[owner]=1 for this cycle, last-served pointer SHALL update to owner, next state IDLE.
REQ-022 Latency: req seen in IDLE at cycle t gives gnt at t+1 and done exactly one cycle after mm_done.
REQ-023 req SHALL be sampled only in IDLE; req changes in other states are ignored and a dropped req SHALL NOT abort an operation.
REQ-024 A requester holding req after its done SHALL be re-arbitrated in the next IDLE cycle (minimum IDLE dwell one cycle).
REQ-025 mm_done outside WAIT SHALL be ignored with no state or output change.
REQ-026 No arithmetic is performed in this block; all widths pass through unchanged at W bits.

Reset
REQ-027 On resetn=0: state IDLE, gnt=0, done=0, mm_start=0, busy=0, result=0, mm_a/mm_b/mm_m=0, owner=0, last-served pointer=1 (requester 0 wins the first tie).
REQ-028 Reset asserted mid-operation SHALL discard the operation with no done pulse; the multiplier is reset by the same resetn.

Structure
REQ-029 A shared package SHALL hold W, requester count (2), and the FSM state constants.
REQ-030 One sub-module rr_pick2 (combinational 2-way round-robin picker: req, last-served -> one-hot winner) is natural; the multiplier is external to this block.

Verification
REQ-031 Bench SHALL use a multiplier stub returning (a*b) mod m with mm_done 5 cycles after mm_start.
REQ-032 Single request: req=01, a0=3, b0=5, m=7 -> gnt=01 one cycle later, mm_start 1 cycle, done=01 with result=1.
REQ-033 Simultaneous after reset: req=11, a0=2,b0=3,a1=4,b1=4,m=11 -> requester 0 served first (result 6), then requester 1 (result 5), no overlap.
REQ-034 Fairness: req=11 held for 4 operations -> grant order 0,1,0,1.
REQ-035 Reset mid-WAIT: resetn low 2 cycles at 3rd WAIT cycle -> no done pulse, all outputs 0, next req=10 granted normally.
REQ-036 Spurious mm_done in IDLE and req drop during WAIT -> no output change; in-flight operation still completes with correct done.
